snake_body_controller: RTL

//  Consumer of the 2-bit navigation direction: on each move tick, advances the snake head one grid cell
//  in the commanded direction, shifts the body segment chain, and grows on target hit.

---
 rtl/snake_pkg.sv | 21 ++
 rtl/snake_segment_match.sv | 38 +++
 rtl/snake_body_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Purpose : Shared grid geometry and direction encoding for the snake body
//           controller and its helpers.
// Contents: GRID_W/GRID_H grid size, X_W/Y_W coordinate widths, LEN_W length
//           counter width, DIR_* direction codes driven by the navigation FSM.
// ---------------------------------------------------------------------------
package snake_pkg;

  localparam int GRID_W = 160;
  localparam int GRID_H = 120;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int LEN_W  = 6;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

endpackage

// File: rtl/snake_segment_match.sv
// ---------------------------------------------------------------------------
// snake_segment_match
// Purpose : Parallel comparator of one probe cell against every stored
//           segment, counting only segments whose index lies in
//           [i_firstIdx, i_endIdx).
// Ports   : i_segX/i_segY   all segment coordinates (index 0 = head)
//           i_probeX/Y      cell under test
//           i_firstIdx      lowest segment index allowed to match
//           i_endIdx        one past the highest index allowed to match
//           o_hit           combinational: some allowed segment equals probe
// ---------------------------------------------------------------------------
module snake_segment_match
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic [MAX_LEN-1:0][X_W-1:0] i_segX,
  input  logic [MAX_LEN-1:0][Y_W-1:0] i_segY,
  input  logic [X_W-1:0]              i_probeX,
  input  logic [Y_W-1:0]              i_probeY,
  input  logic [LEN_W-1:0]            i_firstIdx,
  input  logic [LEN_W-1:0]            i_endIdx,
  output logic                        o_hit
);

  // Index window turns the full-depth compare into a length-aware one, so
  // stale cells beyond the active length can never report a hit.
  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i >= int'(i_firstIdx)) && (i < int'(i_endIdx)) &&
          (i_segX[i] == i_probeX) && (i_segY[i] == i_probeY)) begin
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body_controller.sv
// ---------------------------------------------------------------------------
// snake_body_controller
// Purpose : Advances the snake head one cell per enabled move tick in the
//           commanded direction (with toroidal wrap), shifts the body chain,
//           grows on target hit, flags self-collision and answers a
//           registered "is this cell snake?" query for the pixel path.
// Ports   : i_clk, i_reset (sync, active high)
//           i_navState      direction 0=UP 1=LEFT 2=RIGHT 3=DOWN
//           i_moveTick      one-cycle advance request
//           i_enable        0 pauses movement
//           i_targetX/Y     target cell
//           i_queryX/Y      cell probed by the pixel path
//           o_headX/Y       segment 0
//           o_length        active segment count
//           o_targetReached one-cycle pulse after a move onto the target
//           o_selfHit       one-cycle pulse after a move onto the body
//           o_queryHit      query result, one cycle after the probe
// ---------------------------------------------------------------------------
module snake_body_controller
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int START_X  = 80,
  parameter int START_Y  = 60
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_navState,
  input  logic             i_moveTick,
  input  logic             i_enable,
  input  logic [X_W-1:0]   i_targetX,
  input  logic [Y_W-1:0]   i_targetY,
  input  logic [X_W-1:0]   i_queryX,
  input  logic [Y_W-1:0]   i_queryY,
  output logic [X_W-1:0]   o_headX,
  output logic [Y_W-1:0]   o_headY,
  output logic [LEN_W-1:0] o_length,
  output logic             o_targetReached,
  output logic             o_selfHit,
  output logic             o_queryHit
);

  logic [MAX_LEN-1:0][X_W-1:0] r_segX;
  logic [MAX_LEN-1:0][Y_W-1:0] r_segY;
  logic [LEN_W-1:0]            r_length;
  logic                        r_targetReached;
  logic                        r_selfHit;
  logic                        r_queryHit;

  logic [X_W-1:0]   w_nextX;
  logic [Y_W-1:0]   w_nextY;
  logic             w_move;
  logic             w_grow;
  logic [LEN_W-1:0] w_collideEnd;
  logic             w_selfHit;
  logic             w_queryHit;

  // Candidate head position; each axis wraps to the opposite edge.
  always_comb begin
    w_nextX = r_segX[0];
    w_nextY = r_segY[0];
    case (i_navState)
      DIR_UP:    w_nextY = (r_segY[0] == '0) ? Y_W'(GRID_H - 1) : r_segY[0] - Y_W'(1);
      DIR_DOWN:  w_nextY = (r_segY[0] == Y_W'(GRID_H - 1)) ? '0 : r_segY[0] + Y_W'(1);
      DIR_LEFT:  w_nextX = (r_segX[0] == '0) ? X_W'(GRID_W - 1) : r_segX[0] - X_W'(1);
      default:   w_nextX = (r_segX[0] == X_W'(GRID_W - 1)) ? '0 : r_segX[0] + X_W'(1);
    endcase
  end

  assign w_move = i_moveTick & i_enable;
  assign w_grow = (w_nextX == i_targetX) && (w_nextY == i_targetY);

  // The tail cell is vacated by a plain move, so it only counts as body
  // when the snake grows and the tail stays put.
  assign w_collideEnd = w_grow ? r_length : r_length - LEN_W'(1);

  snake_segment_match #(.MAX_LEN(MAX_LEN)) uCollideMatch (
    .i_segX     (r_segX),
    .i_segY     (r_segY),
    .i_probeX   (w_nextX),
    .i_probeY   (w_nextY),
    .i_firstIdx (LEN_W'(1)),
    .i_endIdx   (w_collideEnd),
    .o_hit      (w_selfHit)
  );

  snake_segment_match #(.MAX_LEN(MAX_LEN)) uQueryMatch (
    .i_segX     (r_segX),
    .i_segY     (r_segY),
    .i_probeX   (i_queryX),
    .i_probeY   (i_queryY),
    .i_firstIdx ('0),
    .i_endIdx   (r_length),
    .o_hit      (w_queryHit)
  );

  // Segment chain, length counter and result pulses. Reset lays the body out
  // vertically below the head so the default UP heading is collision free.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_segX[i] <= X_W'(START_X);
        r_segY[i] <= Y_W'((START_Y + i) % GRID_H);
      end
      r_length        <= LEN_W'(INIT_LEN);
      r_targetReached <= 1'b0;
      r_selfHit       <= 1'b0;
      r_queryHit      <= 1'b0;
    end else begin
      r_queryHit      <= w_queryHit;
      r_targetReached <= w_move & w_grow;
      r_selfHit       <= w_move & w_selfHit;
      if (w_move) begin
        r_segX <= {r_segX[MAX_LEN-2:0], w_nextX};
        r_segY <= {r_segY[MAX_LEN-2:0], w_nextY};
        if (w_grow && (r_length < LEN_W'(MAX_LEN))) begin
          r_length <= r_length + LEN_W'(1);
        end
      end
    end
  end

  assign o_headX         = r_segX[0];
  assign o_headY         = r_segY[0];
  assign o_length        = r_length;
  assign o_targetReached = r_targetReached;
  assign o_selfHit       = r_selfHit;
  assign o_queryHit      = r_queryHit;

endmodule
